// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and defaults for the FIFO write-side logic.
// No ports. Provides the arbiter state enumeration and the default burst length.
package fifo_pkg;
    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_t;
    localparam int MAX_BURST_DEF = 4;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin winner among four requesters.
// Ports: req    - request vector
//        rr_ptr - highest-priority requester index
//        grant  - one-hot winner, zero when no request is pending
module rr_pick (
    input  logic [3:0] req,
    input  logic [1:0] rr_ptr,
    output logic [3:0] grant
);
    logic [3:0] rot;
    logic [1:0] off;
    logic [1:0] idx;
    // Rotate so the requester at rr_ptr lands in bit 0, then take the lowest set bit.
    assign rot   = 4'({req, req} >> rr_ptr);
    assign off   = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
    assign idx   = rr_ptr + off;
    assign grant = |req ? 4'b0001 << idx : 4'b0000;
endmodule

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin burst arbiter feeding four requesters into one FIFO write port.
// Ports: clk, reset (async, active-low)
//        req/req_data - per-requester beat valid and packed data (lane i at [i*DW +: DW])
//        ack          - one-hot beat accept
//        fifo_full    - FIFO back-pressure; fifo_write_e/fifo_data - FIFO write port
//        busy         - a grant is active; owner - current grant holder (0 when idle)
module fifo_wr_arb
    import fifo_pkg::*;
#(
    parameter int DW        = 8,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    ack,
    input  logic               fifo_full,
    output logic               fifo_write_e,
    output logic [DW-1:0]      fifo_data,
    output logic               busy,
    output logic [1:0]         owner
);
    arb_state_t state, state_nx;
    logic [1:0] owner_nx, rr_ptr, rr_ptr_nx, pick_idx;
    logic [2:0] burst_cnt, burst_cnt_nx;
    logic [3:0] pick;
    logic       beat;

    rr_pick u_rr_pick (
        .req   (req),
        .rr_ptr(rr_ptr),
        .grant (pick)
    );

    assign pick_idx     = {pick[3] | pick[2], pick[3] | pick[1]};
    assign beat         = state == GRANT && req[owner] && !fifo_full;
    assign ack          = beat ? NREQ'(1) << owner : '0;
    assign fifo_write_e = |ack;
    // Forced to zero while reset is held so nothing stale reaches the FIFO bus.
    assign fifo_data    = reset ? req_data[owner*DW +: DW] : '0;
    assign busy         = state == GRANT;

    always_comb begin
        state_nx     = state;
        owner_nx     = owner;
        rr_ptr_nx    = rr_ptr;
        burst_cnt_nx = burst_cnt;
        if (state == IDLE) begin
            if (|req) begin
                state_nx     = GRANT;
                owner_nx     = pick_idx;
                burst_cnt_nx = '0;
            end
        end else begin
            burst_cnt_nx = beat ? burst_cnt + 3'd1 : burst_cnt;
            // A stalled grant only ends if its owner withdraws.
            if ((beat && burst_cnt == 3'(MAX_BURST - 1)) || !req[owner]) begin
                state_nx  = IDLE;
                owner_nx  = '0;
                rr_ptr_nx = owner + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nx;
            owner     <= owner_nx;
            rr_ptr    <= rr_ptr_nx;
            burst_cnt <= burst_cnt_nx;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: directed scenarios plus randomized traffic against a transaction-level model.
module tb_fifo_wr_arb;
    localparam int MB = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic        fifo_full = 1'b0;
    logic [3:0]  ack;
    logic        fifo_write_e;
    logic [7:0]  fifo_data;
    logic        busy;
    logic [1:0]  owner;

    logic [3:0]  o_ack;
    logic        o_we;
    logic [7:0]  o_data;
    logic        o_busy;
    logic [1:0]  o_owner;

    int n_cmp = 0;
    int n_bad = 0;

    bit m_granted;
    int m_holder, m_beats, m_next;
    int wt[4];

    fifo_wr_arb #(.DW(8), .NREQ(4), .MAX_BURST(MB)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .fifo_full   (fifo_full),
        .fifo_write_e(fifo_write_e),
        .fifo_data   (fifo_data),
        .busy        (busy),
        .owner       (owner)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1);
    end

    function automatic logic [7:0] lane(int i);
        return req_data[i*8 +: 8];
    endfunction

    task automatic tick();
        @(negedge clk);
        o_ack   = ack;
        o_we    = fifo_write_e;
        o_data  = fifo_data;
        o_busy  = busy;
        o_owner = owner;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        req       = '0;
        fifo_full = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        req      = 4'b1111;
        req_data = 32'hA5C3_5A3C;
        @(negedge clk);
        n_cmp++;
        if ({ack, fifo_write_e, fifo_data, busy, owner} !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_state: got ack=%b we=%b data=%h busy=%b owner=%0d, want all zero",
                     ack, fifo_write_e, fifo_data, busy, owner);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_burst_pair();
        logic [3:0] e [12];
        e = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd0, 4'd4, 4'd4, 4'd4, 4'd4, 4'd0, 4'd1};
        do_reset();
        req      = 4'b0101;
        req_data = $urandom;
        for (int c = 0; c < 12; c++) begin
            tick();
            n_cmp++;
            if (o_ack !== e[c] || o_we !== (e[c] != 0)) begin
                n_bad++;
                $display("FAIL burst_pair c%0d: ack=%b we=%b, want ack=%b we=%b", c, o_ack, o_we, e[c], e[c] != 0);
            end
            if (e[c] != 0) begin
                n_cmp++;
                if (o_data !== lane(e[c] == 4'd4 ? 2 : 0)) begin
                    n_bad++;
                    $display("FAIL burst_pair_data c%0d: got %h want %h", c, o_data, lane(e[c] == 4'd4 ? 2 : 0));
                end
            end
        end
    endtask

    task automatic test_all_req();
        logic [3:0] e;
        do_reset();
        req      = 4'b1111;
        req_data = $urandom;
        for (int c = 0; c < 26; c++) begin
            e = (c == 0 || (c - 1) % 5 == 4) ? 4'd0 : 4'(1 << (((c - 1) / 5) % 4));
            tick();
            n_cmp++;
            if (o_ack !== e || o_we !== (e != 0) || o_busy !== (e != 0)) begin
                n_bad++;
                $display("FAIL all_req c%0d: ack=%b we=%b busy=%b, want ack=%b", c, o_ack, o_we, o_busy, e);
            end
        end
    endtask

    task automatic test_full_stall();
        logic [3:0] e;
        logic       eb;
        do_reset();
        req      = 4'b0010;
        req_data = $urandom;
        for (int c = 0; c < 9; c++) begin
            fifo_full = (c >= 3 && c <= 5);
            e  = (c == 1 || c == 2 || c == 6 || c == 7) ? 4'b0010 : 4'b0000;
            eb = (c >= 1 && c <= 7);
            tick();
            n_cmp++;
            if (o_ack !== e || o_we !== (e != 0) || o_busy !== eb) begin
                n_bad++;
                $display("FAIL full_stall c%0d: ack=%b we=%b busy=%b, want ack=%b busy=%b", c, o_ack, o_we, o_busy, e, eb);
            end
        end
        fifo_full = 1'b0;
    endtask

    task automatic test_drop();
        do_reset();
        req      = 4'b1000;
        req_data = $urandom;
        tick();
        n_cmp++;
        if (o_ack !== 4'b0000 || o_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL drop_idle: ack=%b busy=%b, want 0000/0", o_ack, o_busy);
        end
        tick();
        n_cmp++;
        if (o_ack !== 4'b1000 || o_owner !== 2'd3) begin
            n_bad++;
            $display("FAIL drop_beat: ack=%b owner=%0d, want 1000/3", o_ack, o_owner);
        end
        req = 4'b0011;
        tick();
        n_cmp++;
        if (o_ack !== 4'b0000 || o_we !== 1'b0 || o_busy !== 1'b1 || o_owner !== 2'd3) begin
            n_bad++;
            $display("FAIL drop_release: ack=%b we=%b busy=%b owner=%0d, want 0000/0/1/3", o_ack, o_we, o_busy, o_owner);
        end
        tick();
        n_cmp++;
        if (o_busy !== 1'b0 || o_owner !== 2'd0) begin
            n_bad++;
            $display("FAIL drop_gap: busy=%b owner=%0d, want 0/0", o_busy, o_owner);
        end
        tick();
        n_cmp++;
        if (o_ack !== 4'b0001) begin
            n_bad++;
            $display("FAIL drop_next: ack=%b, want 0001", o_ack);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req      = 4'b0100;
        req_data = $urandom;
        tick();
        tick();
        #2;
        n_cmp++;
        if (fifo_write_e !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid_pre: we=%b, want 1", fifo_write_e);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (fifo_write_e !== 1'b0 || ack !== 4'b0000 || busy !== 1'b0 || fifo_data !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_mid_abort: we=%b ack=%b busy=%b data=%h, want all zero", fifo_write_e, ack, busy, fifo_data);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        req   = 4'b1111;
        tick();
        n_cmp++;
        if (o_ack !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_mid_idle: ack=%b, want 0000", o_ack);
        end
        tick();
        n_cmp++;
        if (o_ack !== 4'b0001) begin
            n_bad++;
            $display("FAIL reset_mid_restart: ack=%b, want 0001", o_ack);
        end
    endtask

    task automatic test_data();
        int writes = 0;
        do_reset();
        req      = 4'b0010;
        req_data = $urandom;
        req_data[15:8] = 8'hA5;
        for (int c = 0; c < 12; c++) begin
            tick();
            n_cmp++;
            if (o_we !== |(o_ack & req)) begin
                n_bad++;
                $display("FAIL data_we c%0d: we=%b, accepted=%b", c, o_we, o_ack & req);
            end
            if (o_we) begin
                writes++;
                n_cmp++;
                if (o_data !== 8'hA5) begin
                    n_bad++;
                    $display("FAIL data_value c%0d: got %h want a5", c, o_data);
                end
            end
        end
        n_cmp++;
        if (writes != 9) begin
            n_bad++;
            $display("FAIL data_count: got %0d writes want 9", writes);
        end
    endtask

    task automatic test_random();
        logic [3:0]  e_ack;
        logic [15:0] e_vec;
        int          e_own;
        bit          found;
        do_reset();
        m_granted = 0;
        m_next    = 0;
        m_beats   = 0;
        m_holder  = 0;
        for (int i = 0; i < 4; i++) wt[i] = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!req[i]) req_data[i*8 +: 8] = 8'($urandom);
                if (req[i]) begin
                    if ($urandom_range(7) == 0) req[i] = 1'b0;
                end else if ($urandom_range(2) == 0) begin
                    req[i] = 1'b1;
                end
            end
            fifo_full = ($urandom_range(3) == 0);
            e_own = m_granted ? m_holder : 0;
            e_ack = (m_granted && req[m_holder] && !fifo_full) ? 4'(1 << m_holder) : 4'd0;
            e_vec = {e_ack, e_ack != 0, lane(e_own), m_granted, 2'(e_own)};
            tick();
            n_cmp++;
            if ({o_ack, o_we, o_data, o_busy, o_owner} !== e_vec) begin
                n_bad++;
                $display("FAIL random c%0d: got ack=%b we=%b data=%h busy=%b owner=%0d, want ack=%b we=%b data=%h busy=%b owner=%0d",
                         c, o_ack, o_we, o_data, o_busy, o_owner, e_vec[15:12], e_vec[11], e_vec[10:3], e_vec[2], e_vec[1:0]);
            end
            for (int i = 0; i < 4; i++) if (!req[i]) wt[i] = 0;
            if (!m_granted) begin
                found = 0;
                for (int k = 0; k < 4; k++) begin
                    if (!found && req[(m_next + k) % 4]) begin
                        found     = 1;
                        m_holder  = (m_next + k) % 4;
                        m_granted = 1;
                        m_beats   = 0;
                    end
                end
                if (found) begin
                    for (int i = 0; i < 4; i++) begin
                        if (i != m_holder && req[i]) wt[i]++;
                        n_cmp++;
                        if (wt[i] > 3) begin
                            n_bad++;
                            $display("FAIL fairness c%0d: requester %0d waited %0d grants, want <= 3", c, i, wt[i]);
                        end
                    end
                    wt[m_holder] = 0;
                end
            end else begin
                if (e_ack != 0) m_beats++;
                if (m_beats == MB || !req[m_holder]) begin
                    m_granted = 0;
                    m_next    = (m_holder + 1) % 4;
                end
            end
        end
        fifo_full = 1'b0;
    endtask

    initial begin
        test_reset();
        test_burst_pair();
        test_all_req();
        test_full_stall();
        test_drop();
        test_reset_mid();
        test_data();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
